fp_muladd_sequencer: RTL
========================

Name: fp_muladd_sequencer

Overview:
- Multi-cycle controller in front of the shared single-precision multiply/add datapath (FMUL, FADD, FSUB primitives, combinational).
- Accepts one FP arithmetic op per valid/ready handshake and runs it on the datapath.
- Splits the fused family (FMADD/FMSUB/FNMADD/FNMSUB) into a multiply phase and an add phase, with a registered intermediate product.
- Returns the result and the accumulated fflags on a valid/ready output handshake, with backpressure.

Parameters:
WIDTH, 32, operand/result width (1 sign + 8 exponent + 23 fraction)
FLAG_WIDTH, 5, fflags width, bits {NV,DZ,OF,UF,NX} MSB to LSB

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
reqValid  in  1  request valid
reqReady  out  1  request accepted when reqValid&&reqReady
reqOp  in  3  0 FADD, 1 FSUB, 2 FMUL, 3 FMADD, 4 FMSUB, 5 FNMADD, 6 FNMSUB, 7 reserved
reqRm  in  3  rounding mode
reqSrc1, reqSrc2, reqSrc3  in  WIDTH each  operands
flush  in  1  synchronous abort of in-flight op
dpOp  out  2  datapath primitive: 0 FADD, 1 FSUB, 2 FMUL
dpRm  out  3  rounding mode to datapath
dpSrc1, dpSrc2  out  WIDTH each  datapath operands
dpResult  in  WIDTH  datapath result (combinational from dp* outputs)
dpFlags  in  FLAG_WIDTH  datapath flags
respValid  out  1  result valid
respReady  in  1  consumer ready
respResult  out  WIDTH  result
respFlags  out  FLAG_WIDTH  accumulated flags
busy  out  1  state != IDLE
opCount  out  32  completed-op counter, increments on resp handshake, wraps at 2^32

Behaviour:
- Reset (rst low, async): state IDLE.
  - respValid=0, respResult=0, respFlags=0, opCount=0.
  - All operand, product and flag registers = 0.
  - dp* outputs = 0 (dpOp=FADD).
- Operand registers (op, rm, src1-3) load on request handshake only.
- States: IDLE, EXEC, MUL, ADD, DONE.
- IDLE:
  - reqReady=1.
  - On handshake: op in {0,1,2} -> EXEC; op in {3..6} -> MUL.
  - op 7: no datapath phase; go directly to DONE with result 0x7FC00000 and flags NV only.
- EXEC (1 cycle):
  - dpOp = stored op; dpSrc1 = src1; dpSrc2 = src2.
  - At clock edge: capture dpResult and dpFlags into respResult/respFlags -> DONE.
- MUL (1 cycle):
  - dpOp = FMUL; dpSrc1 = src1; dpSrc2 = src2.
  - Capture product and flags into prod/accFlags -> ADD.
  - The product sign bit is inverted on capture for FNMADD and FNMSUB.
- ADD (1 cycle):
  - dpSrc1 = prod; dpSrc2 = src3.
  - dpOp = FADD for FMADD and FNMSUB; FSUB for FMSUB and FNMADD.
  - respFlags = accFlags | dpFlags; respResult = dpResult -> DONE.
  - The add phase always runs, even if the multiply produced NaN or raised NV.
- Outside EXEC/MUL/ADD the dp* outputs hold their last values; dpRm = stored rm at all times.
- DONE:
  - respValid=1; respResult and respFlags stable until the handshake.
  - On respValid&&respReady: opCount++.
  - Same cycle, reqReady=respReady. A simultaneous request handshake goes straight to EXEC/MUL, giving back-to-back operation.
  - Otherwise the block returns to IDLE.
- reqReady = (state==IDLE) || (state==DONE && respReady).
- Latency from request handshake to respValid:
  - 2 cycles for FADD, FSUB, FMUL.
  - 3 cycles for the fused ops.
  - 1 cycle for reserved op 7.
- Fused ops round twice (after the multiply, then after the add). This is not IEEE-fused; the result must bit-match FMUL followed by FADD/FSUB.
- flush:
  - Highest priority. Next state IDLE; respValid=0; no opCount increment.
  - reqReady=0 during a flush cycle, so a concurrent request is not accepted.
  - Flush in IDLE has no effect.
- rst asserted mid-operation: immediate return to reset values; the in-flight op is lost.
- Simultaneous flush with respValid&&respReady: the flush wins and no handshake is counted.
- Outputs are registered except reqReady, busy and the dp* operand muxing.

Test Plan:
- FMUL 0x40000000*0x40400000, respReady=1 -> respValid 2 cycles after handshake, result 0x40C00000, flags 0, opCount=1.
- FMADD src 0x40000000, 0x40400000, src3 0x3F800000 -> 3-cycle latency, 0x40E00000; dpOp sequence FMUL then FADD. FNMADD same operands -> 0xC0E00000; FMSUB -> 0x40A00000.
- FMUL 0x7F800000*0x00000000 (inf*0) -> 0x7FC00000 class NaN, NV set. As FMADD with src3 0x3F800000 -> NV carried into respFlags.
- Back-to-back: three FADDs with reqValid held and respReady=1 -> one accepted every 2 cycles, opCount=3. With respReady=0 for 5 cycles, respResult holds, reqReady=0, no second op accepted.
- Flush asserted in the MUL cycle of an FMSUB -> next cycle IDLE, respValid never rises, opCount unchanged. A new FADD 0x3F800000+0x3F800000 -> 0x40000000.
- rst low mid-ADD, asynchronously between edges -> all outputs at reset values immediately, busy=0. Request 7 after release -> 1-cycle latency, 0x7FC00000, flags 0x10.

Source files
------------

// File: rtl/fp_muladd_sequencer.sv
// Sequencer in front of a shared combinational FP multiply/add datapath.
// Fused ops run as a multiply phase and an add phase, with a registered product between them.
module fp_muladd_sequencer #(
  parameter int WIDTH      = 32,
  parameter int FLAG_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [2:0]            reqOp,
  input  logic [2:0]            reqRm,
  input  logic [WIDTH-1:0]      reqSrc1,
  input  logic [WIDTH-1:0]      reqSrc2,
  input  logic [WIDTH-1:0]      reqSrc3,
  input  logic                  flush,
  output logic [1:0]            dpOp,
  output logic [2:0]            dpRm,
  output logic [WIDTH-1:0]      dpSrc1,
  output logic [WIDTH-1:0]      dpSrc2,
  input  logic [WIDTH-1:0]      dpResult,
  input  logic [FLAG_WIDTH-1:0] dpFlags,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [WIDTH-1:0]      respResult,
  output logic [FLAG_WIDTH-1:0] respFlags,
  output logic                  busy,
  output logic [31:0]           opCount
);

  typedef enum logic [2:0] {IDLE, EXEC, MUL, ADD, DONE} state_t;

  localparam logic [1:0] DP_FADD = 2'd0;
  localparam logic [1:0] DP_FSUB = 2'd1;
  localparam logic [1:0] DP_FMUL = 2'd2;

  localparam logic [2:0] OP_FMSUB  = 3'd4;
  localparam logic [2:0] OP_FNMADD = 3'd5;
  localparam logic [2:0] OP_FNMSUB = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam logic [WIDTH-1:0]      CANON_NAN = WIDTH'(32'h7FC0_0000);
  localparam logic [FLAG_WIDTH-1:0] FLAG_NV   = {1'b1, {(FLAG_WIDTH-1){1'b0}}};

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [2:0]            rm_q, rm_d;
  logic [WIDTH-1:0]      src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;
  logic [WIDTH-1:0]      prod_q, prod_d;
  logic [FLAG_WIDTH-1:0] acc_flags_q, acc_flags_d;
  logic [WIDTH-1:0]      resp_result_q, resp_result_d;
  logic [FLAG_WIDTH-1:0] resp_flags_q, resp_flags_d;
  logic [31:0]           op_count_q, op_count_d;
  logic [1:0]            dp_op_q, dp_op_d;
  logic [WIDTH-1:0]      dp_src1_q, dp_src1_d, dp_src2_q, dp_src2_d;
  logic                  req_fire;
  logic                  neg_prod;
  logic                  sub_phase;

  assign reqReady   = !flush && ((state_q == IDLE) || ((state_q == DONE) && respReady));
  assign req_fire   = reqValid && reqReady;
  assign neg_prod   = (op_q == OP_FNMADD) || (op_q == OP_FNMSUB);
  assign sub_phase  = (op_q == OP_FMSUB) || (op_q == OP_FNMADD);

  assign respValid  = (state_q == DONE);
  assign respResult = resp_result_q;
  assign respFlags  = resp_flags_q;
  assign busy       = (state_q != IDLE);
  assign opCount    = op_count_q;
  assign dpRm       = rm_q;
  assign dpOp       = dp_op_d;
  assign dpSrc1     = dp_src1_d;
  assign dpSrc2     = dp_src2_d;

  // Kept apart from the next-state logic so the external datapath closes no combinational loop.
  always_comb begin
    dp_op_d   = dp_op_q;
    dp_src1_d = dp_src1_q;
    dp_src2_d = dp_src2_q;
    case (state_q)
      EXEC: begin
        dp_op_d   = op_q[1:0];
        dp_src1_d = src1_q;
        dp_src2_d = src2_q;
      end
      MUL: begin
        dp_op_d   = DP_FMUL;
        dp_src1_d = src1_q;
        dp_src2_d = src2_q;
      end
      ADD: begin
        dp_op_d   = sub_phase ? DP_FSUB : DP_FADD;
        dp_src1_d = prod_q;
        dp_src2_d = src3_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rm_d          = rm_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    src3_d        = src3_q;
    prod_d        = prod_q;
    acc_flags_d   = acc_flags_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    op_count_d    = op_count_q;

    case (state_q)
      EXEC: begin
        resp_result_d = dpResult;
        resp_flags_d  = dpFlags;
        state_d       = DONE;
      end
      MUL: begin
        prod_d      = {dpResult[WIDTH-1] ^ neg_prod, dpResult[WIDTH-2:0]};
        acc_flags_d = dpFlags;
        state_d     = ADD;
      end
      ADD: begin
        resp_result_d = dpResult;
        resp_flags_d  = acc_flags_q | dpFlags;
        state_d       = DONE;
      end
      DONE: begin
        if (respReady) begin
          op_count_d = op_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: ;
    endcase

    // A new request in IDLE or in a consumed DONE overrides the default next state.
    if (req_fire) begin
      op_d   = reqOp;
      rm_d   = reqRm;
      src1_d = reqSrc1;
      src2_d = reqSrc2;
      src3_d = reqSrc3;
      if (reqOp <= 3'd2) begin
        state_d = EXEC;
      end else if (reqOp == OP_RSVD) begin
        resp_result_d = CANON_NAN;
        resp_flags_d  = FLAG_NV;
        state_d       = DONE;
      end else begin
        state_d = MUL;
      end
    end

    if (flush) begin
      state_d       = IDLE;
      prod_d        = prod_q;
      acc_flags_d   = acc_flags_q;
      resp_result_d = resp_result_q;
      resp_flags_d  = resp_flags_q;
      op_count_d    = op_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      rm_q          <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      src3_q        <= '0;
      prod_q        <= '0;
      acc_flags_q   <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      op_count_q    <= '0;
      dp_op_q       <= DP_FADD;
      dp_src1_q     <= '0;
      dp_src2_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rm_q          <= rm_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      src3_q        <= src3_d;
      prod_q        <= prod_d;
      acc_flags_q   <= acc_flags_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      op_count_q    <= op_count_d;
      dp_op_q       <= dp_op_d;
      dp_src1_q     <= dp_src1_d;
      dp_src2_q     <= dp_src2_d;
    end
  end

endmodule
